// File: rtl/fir_mac_seq.sv
// fir_mac_seq: single-MAC multicycle FIR, TAPS taps, signed Q(WI.WF) data,
// coefficients and output. Guard-bit accumulator, saturating output,
// runtime coefficient write port, valid/ready on both streams.
// Optional build macro: FIR_ROUND_EN (round-half-up before the output shift;
// default build truncates toward -inf).
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high; a source keeps valid and data stable until that edge, and
// ready may be observed by the source without combinational dependence on
// valid (in_ready and out_valid are registered outputs).
module fir_mac_seq #(
    parameter int TAPS = 8,
    parameter int WI   = 1,
    parameter int WF   = 15,
    parameter int GB   = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic signed [WI+WF-1:0]     in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [WI+WF-1:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [WI+WF-1:0]     coef_din,
    output logic                        coef_drop,
    output logic                        busy,
    output logic [1:0]                  state_dbg
);
    localparam int W    = WI + WF;
    localparam int AW   = $clog2(TAPS);
    localparam int KW   = $clog2(TAPS + 1);
    localparam int PW   = 2 * W;
    localparam int ACCW = PW + GB;

    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};
`ifdef FIR_ROUND_EN
    localparam logic signed [ACCW-1:0] RND_K = ACCW'(1) <<< (WF - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 state;
    logic signed [W-1:0]    dline [TAPS];
    logic signed [W-1:0]    coef  [TAPS];
    logic [AW-1:0]          wptr;
    logic [KW-1:0]          k;
    logic signed [ACCW-1:0] acc;

    logic [AW-1:0]          rd_idx;
    logic [AW-1:0]          h_idx;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_adj;
    logic signed [ACCW-1:0] acc_shr;
    logic signed [W-1:0]    sat_val;
    logic                   coef_addr_ok;

    assign state_dbg = state;

    // Tap addressing and product: x[n-k] lives at (wptr-k) mod TAPS.
    // On the final normalise cycle (k == TAPS) the product is unused.
    always_comb begin
        rd_idx   = AW'((int'(wptr) + TAPS - int'(k)) % TAPS);
        h_idx    = AW'(int'(k) % TAPS);
        prod     = coef[h_idx] * dline[rd_idx];
        prod_ext = {{GB{prod[PW-1]}}, prod};
    end

    // Output scaling: optional rounding, arithmetic shift by WF, saturate.
    always_comb begin
`ifdef FIR_ROUND_EN
        acc_adj = acc + RND_K;
`else
        acc_adj = acc;
`endif
        acc_shr = acc_adj >>> WF;
        if (acc_shr > MAXV)
            sat_val = {1'b0, {(W-1){1'b1}}};
        else if (acc_shr < MINV)
            sat_val = {1'b1, {(W-1){1'b0}}};
        else
            sat_val = acc_shr[W-1:0];
    end

    assign coef_addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

    // Control FSM, delay line, coefficient store and accumulator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_drop <= 1'b0;
            busy      <= 1'b0;
            wptr      <= '0;
            k         <= '0;
            acc       <= '0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            // A write is only honoured in IDLE with no sample accepted alongside it.
            coef_drop <= coef_we && !((state == S_IDLE) && !in_valid);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dline[wptr] <= in_data;
                        acc         <= '0;
                        k           <= '0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_MAC;
                    end else if (coef_we && coef_addr_ok) begin
                        coef[coef_addr] <= coef_din;
                    end
                end
                S_MAC: begin
                    if (k == KW'(TAPS)) begin
                        out_data  <= sat_val;
                        out_valid <= 1'b1;
                        wptr      <= (wptr == AW'(TAPS - 1)) ? '0 : wptr + 1'b1;
                        state     <= S_OUT;
                    end else begin
                        acc <= acc + prod_ext;
                        k   <= k + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed + randomized bench for fir_mac_seq with a
// sum-of-products reference model and an expected-output queue.
module tb_fir_mac_seq;
    localparam int TAPS = 8;
    localparam int WI   = 1;
    localparam int WF   = 15;
    localparam int GB   = 4;
    localparam int W    = WI + WF;
    localparam int AW   = $clog2(TAPS);
    localparam longint MAXI = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINI = -(longint'(1) <<< (W - 1));

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [W-1:0]  coef_din = '0;
    logic          coef_drop;
    logic          busy;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    // scoreboard and reference model state
    logic [W-1:0] exp_q[$];
    int h_m [TAPS];
    int x_m [TAPS];   // x_m[k] = x[n-k]

    fir_mac_seq #(.TAPS(TAPS), .WI(WI), .WF(WF), .GB(GB)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
        .coef_drop(coef_drop), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            h_m[i] = 0;
            x_m[i] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic logic [W-1:0] model_push(input logic [W-1:0] x);
        longint acc;
        longint q;
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = $signed(x);
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += longint'(h_m[i]) * longint'(x_m[i]);
`ifdef FIR_ROUND_EN
        acc += longint'(1) <<< (WF - 1);
`endif
        q = acc >>> WF;
        if (q > MAXI) q = MAXI;
        if (q < MINI) q = MINI;
        return W'(q);
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
    endtask

    task automatic write_coef(input int a, input logic [W-1:0] v);
        coef_we = 1'b1; coef_addr = AW'(a); coef_din = v;
        @(negedge CLK);
        coef_we = 1'b0;
        h_m[a] = int'($signed(v));
        chk("coef_drop_idle", 32'(coef_drop), 32'd0);
    endtask

    task automatic accept(input logic [W-1:0] x);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_data = x; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        exp_q.push_back(model_push(x));
    endtask

    // lat0 = number of negedges already spent since the accept edge
    task automatic wait_out(input string tag, input int lat0, output logic [W-1:0] obs);
        int lat;
        logic [W-1:0] e;
        lat = lat0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(TAPS + 1));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        obs = out_data;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_data"}, 32'(out_data), 32'(e));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("hs_out_valid_low", 32'(out_valid), 32'd0);
        chk("hs_in_ready_high", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [W-1:0] x, output logic [W-1:0] obs);
        accept(x);
        wait_out(tag, 0, obs);
        handshake();
    endtask

    task automatic load_impulse_coefs();
        logic [W-1:0] h_tbl [4];
        h_tbl = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        for (int i = 0; i < TAPS; i++) write_coef(i, (i < 4) ? h_tbl[i] : '0);
    endtask

    task automatic run_impulse(input string tag);
        logic [W-1:0] tbl [8];
        logic [W-1:0] obs;
        tbl = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            send(tag, (i == 0) ? 16'h4000 : 16'h0000, obs);
            chk({tag, "_table"}, 32'(obs), 32'(tbl[i]));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] obs;
        logic [W-1:0] held;
        logic [W-1:0] xb;

        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        // reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_coef_drop", 32'(coef_drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // impulse response
        load_impulse_coefs();
        run_impulse("impulse");

        // saturation
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send("sat_pos", 16'h7FFF, obs);
        chk("sat_pos_final", 32'(obs), 32'h7FFF);
        for (int i = 0; i < TAPS; i++) send("sat_neg", 16'h8000, obs);
        chk("sat_neg_final", 32'(obs), 32'h8000);
        write_coef(0, 16'h8000);
        for (int i = 1; i < TAPS; i++) write_coef(i, 16'h0000);
        send("neg_one_sq", 16'h8000, obs);
        chk("neg_one_sq_final", 32'(obs), 32'h7FFF);

        // backpressure: hold OUT for 20 cycles with a pending input
        for (int i = 0; i < TAPS; i++) write_coef(i, W'($urandom_range(0, 65535)));
        accept(W'($urandom_range(0, 65535)));
        wait_out("bp_first", 0, held);
        xb = W'($urandom_range(0, 65535));
        in_data = xb; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        in_valid = 1'b0;
        exp_q.push_back(model_push(xb));
        chk("bp_pending_accepted", 32'(in_ready), 32'd0);
        wait_out("bp_second", 0, obs);
        handshake();

        // coefficient write during MAC is dropped
        accept(W'($urandom_range(0, 65535)));
        coef_we = 1'b1; coef_addr = AW'(0); coef_din = 16'h1234;
        @(negedge CLK);
        coef_we = 1'b0;
        chk("drop_mac_pulse", 32'(coef_drop), 32'd1);
        @(negedge CLK);
        chk("drop_mac_single", 32'(coef_drop), 32'd0);
        wait_out("drop_mac", 2, obs);
        handshake();
        // write coincident with an input accept is also dropped
        in_data = W'($urandom_range(0, 65535)); in_valid = 1'b1;
        coef_we = 1'b1; coef_addr = AW'(1); coef_din = 16'h4321;
        @(negedge CLK);
        in_valid = 1'b0; coef_we = 1'b0;
        exp_q.push_back(model_push(in_data));
        chk("drop_accept_pulse", 32'(coef_drop), 32'd1);
        wait_out("drop_accept", 0, obs);
        handshake();
        // same write in IDLE is applied to the next sample
        write_coef(0, 16'h1234);
        send("idle_write", W'($urandom_range(0, 65535)), obs);

        // wrap-around ramp through the delay line
        write_coef(0, 16'h7FFF);
        for (int i = 1; i < TAPS; i++) write_coef(i, 16'h0000);
        for (int n = 0; n < 20; n++) send("ramp", W'(16'h0100 * n), obs);

        // randomized coefficients, data and idle out_ready
        for (int it = 0; it < 16; it++) begin
            if (it % 4 == 0)
                for (int i = 0; i < TAPS; i++) write_coef(i, W'($urandom_range(0, 65535)));
            out_ready = 1'($urandom_range(0, 1));
            accept(W'($urandom_range(0, 65535)));
            wait_out("random", 0, obs);
            handshake();
        end

        // reset mid-MAC
        accept(W'($urandom_range(1, 65535)));
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        send("post_rst_zero_coef", 16'h4000, obs);
        chk("post_rst_zero_value", 32'(obs), 32'd0);
        do_reset();
        load_impulse_coefs();
        run_impulse("impulse_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
